// File: rtl/mastermind_scorer.sv
// Mastermind scoring engine: holds the secret, scores guesses one peg per cycle
// (exact matches first, then colour-only matches), and tracks guess count and win/lose.
module mastermind_scorer #(
   parameter  int PEGS        = 4,
   parameter  int COLOR_W     = 3,
   parameter  int MAX_GUESSES = 8,
   localparam int CNT_W       = $clog2(PEGS + 1),
   localparam int GC_W        = $clog2(MAX_GUESSES + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    new_game,
   input  logic [PEGS*COLOR_W-1:0] code_in,
   input  logic                    start,
   input  logic [PEGS*COLOR_W-1:0] guess_in,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        red,
   output logic [CNT_W-1:0]        white,
   output logic [GC_W-1:0]         guess_count,
   output logic                    win,
   output logic                    lose
);

   localparam int IDX_W  = $clog2(PEGS);
   localparam int CODE_W = PEGS * COLOR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RED   = 2'd1,
      WHITE = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t              state_q;
   logic [CODE_W-1:0]   secret_q;
   logic [CODE_W-1:0]   guess_q;
   logic [PEGS-1:0]     code_used_q;
   logic [PEGS-1:0]     guess_used_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    red_acc_q;
   logic [CNT_W-1:0]    white_acc_q;
   logic [CNT_W-1:0]    red_q;
   logic [CNT_W-1:0]    white_q;
   logic [GC_W-1:0]     guess_count_q;
   logic                busy_q;
   logic                done_q;
   logic                win_q;
   logic                lose_q;

   logic [COLOR_W-1:0]  sec_peg_s;
   logic [COLOR_W-1:0]  gue_peg_s;
   logic                last_s;
   logic                red_hit_s;
   logic                white_hit_s;
   logic [PEGS-1:0]     white_sel_s;
   logic [PEGS-1:0]     guess_used_d;
   logic [CNT_W-1:0]    red_acc_d;
   logic [CNT_W-1:0]    white_acc_d;
   logic [GC_W-1:0]     guess_count_d;
   logic                win_s;
   logic                lose_s;

   // Per-peg match logic; the white search picks the lowest free guess peg of the same colour.
   always_comb begin
      sec_peg_s     = secret_q[int'(idx_q) * COLOR_W +: COLOR_W];
      gue_peg_s     = guess_q[int'(idx_q) * COLOR_W +: COLOR_W];
      last_s        = (idx_q == IDX_W'(PEGS - 1));
      red_hit_s     = (sec_peg_s == gue_peg_s);
      white_hit_s   = 1'b0;
      white_sel_s   = '0;
      for (int j = 0; j < PEGS; j++) begin
         white_sel_s[j] = !code_used_q[idx_q] && !white_hit_s && !guess_used_q[j] &&
                          (guess_q[j*COLOR_W +: COLOR_W] == sec_peg_s);
         white_hit_s    = white_hit_s | white_sel_s[j];
      end
      guess_used_d  = guess_used_q | white_sel_s;
      red_acc_d     = red_acc_q + CNT_W'(red_hit_s);
      white_acc_d   = white_acc_q + CNT_W'(white_hit_s);
      guess_count_d = guess_count_q + GC_W'(1);
      win_s         = (red_acc_q == CNT_W'(PEGS));
      lose_s        = !win_s && (guess_count_d == GC_W'(MAX_GUESSES));
   end

   // Scoring FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         secret_q      <= '0;
         guess_q       <= '0;
         code_used_q   <= '0;
         guess_used_q  <= '0;
         idx_q         <= '0;
         red_acc_q     <= '0;
         white_acc_q   <= '0;
         red_q         <= '0;
         white_q       <= '0;
         guess_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
      end else if (new_game) begin
         state_q       <= IDLE;
         secret_q      <= code_in;
         red_q         <= '0;
         white_q       <= '0;
         guess_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  guess_q      <= guess_in;
                  code_used_q  <= '0;
                  guess_used_q <= '0;
                  idx_q        <= '0;
                  red_acc_q    <= '0;
                  white_acc_q  <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= RED;
               end
            end
            RED: begin
               if (red_hit_s) begin
                  code_used_q[idx_q]  <= 1'b1;
                  guess_used_q[idx_q] <= 1'b1;
               end
               red_acc_q <= red_acc_d;
               if (last_s) begin
                  idx_q   <= '0;
                  state_q <= WHITE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            WHITE: begin
               guess_used_q <= guess_used_d;
               white_acc_q  <= white_acc_d;
               if (last_s) begin
                  red_q         <= red_acc_q;
                  white_q       <= white_acc_d;
                  guess_count_q <= guess_count_d;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  win_q         <= win_s;
                  lose_q        <= lose_s;
                  idx_q         <= '0;
                  state_q       <= (win_s || lose_s) ? OVER : IDLE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            OVER: begin
               state_q <= OVER;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign red         = red_q;
   assign white       = white_q;
   assign guess_count = guess_count_q;
   assign win         = win_q;
   assign lose        = lose_q;

endmodule
